// File: rtl/sram_responder.sv
// sram_responder
//
// Memory responder that sits beside the core in the SoC top. It serves the
// instruction SRAM port (read-only) and the data SRAM port (read/write) from
// one shared word-addressed RAM. It also serves a small configuration window
// holding the LED, display-number, switch, timer and optional compare registers.
// Every read has a fixed one-cycle latency and there are no wait states.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   inst_sram_en/wen/addr/wdata instruction request (wen must be 0, wdata unused)
//   inst_sram_rdata             instruction read data, valid the cycle after the request
//   data_sram_en/wen/addr/wdata data request (wen == 0 means read)
//   data_sram_rdata             data read data, valid the cycle after the request
//   switch                      board switch inputs
//   led, num                    LED and display-number registers
//   bad_access                  sticky error flag: illegal byte-enable pattern, or
//                               a write attempted on the instruction port
//   timer_irq                   (only with TIMER_IRQ_EN) timer == compare interrupt
//
// Optional feature macro: TIMER_IRQ_EN adds the compare register at window
// offset 0x10 and the timer_irq output. Without the macro, offset 0x10 reads 0.
module sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] CONF_HI   = 16'hBFAF,
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic [31:0] num,
    output logic        bad_access
`ifdef TIMER_IRQ_EN
    ,
    output logic        timer_irq
`endif
);

    // Window word offsets (addr[15:2])
    localparam logic [13:0] OFF_LED = 14'd0;
    localparam logic [13:0] OFF_NUM = 14'd1;
    localparam logic [13:0] OFF_SW  = 14'd2;
    localparam logic [13:0] OFF_TMR = 14'd3;
    localparam logic [13:0] OFF_CMP = 14'd4;

    function automatic logic wen_legal(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: wen_legal = 1'b1;
            default:                   wen_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = wen[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] conf_read(input logic [13:0] off,
                                              input logic [15:0] led_v,
                                              input logic [31:0] num_v,
                                              input logic [15:0] sw_v,
                                              input logic [31:0] tmr_v,
                                              input logic [31:0] cmp_v);
        case (off)
            OFF_LED: conf_read = {16'h0, led_v};
            OFF_NUM: conf_read = num_v;
            OFF_SW:  conf_read = {16'h0, sw_v};
            OFF_TMR: conf_read = tmr_v;
            OFF_CMP: conf_read = cmp_v;
            default: conf_read = 32'h0;
        endcase
    endfunction

    logic [31:0] ram [2**RAM_AW];

    logic [31:0] inst_rdata_q, data_rdata_q;
    logic [15:0] led_q;
    logic [31:0] num_q, timer_q, timer_d;
    logic        bad_q;
    logic [31:0] cmp_view;

    // The low address bits and the instruction write data do not take part in
    // any decode.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};

    logic              inst_is_conf, data_is_conf;
    logic [RAM_AW-1:0] inst_idx, data_idx;
    logic [13:0]       data_off;
    logic              inst_rd, data_rd, data_wr_ok, ram_wr, conf_wr;
    logic              inst_bad, data_bad;
    logic [31:0]       inst_conf, data_conf, conf_new;

    assign inst_is_conf = (inst_sram_addr[31:16] == CONF_HI);
    assign data_is_conf = (data_sram_addr[31:16] == CONF_HI);
    assign inst_idx     = inst_sram_addr[RAM_AW+1:2];
    assign data_idx     = data_sram_addr[RAM_AW+1:2];
    assign data_off     = data_sram_addr[15:2];

    assign inst_rd    = inst_sram_en && (inst_sram_wen == 4'b0);
    assign data_rd    = data_sram_en && (data_sram_wen == 4'b0);
    assign data_wr_ok = data_sram_en && (data_sram_wen != 4'b0) && wen_legal(data_sram_wen);
    assign data_bad   = data_sram_en && (data_sram_wen != 4'b0) && !wen_legal(data_sram_wen);
    assign inst_bad   = inst_sram_en && (inst_sram_wen != 4'b0);
    assign ram_wr     = data_wr_ok && !data_is_conf;
    assign conf_wr    = data_wr_ok && data_is_conf;

    assign inst_conf = conf_read(inst_sram_addr[15:2], led_q, num_q, switch, timer_q, cmp_view);
    assign data_conf = conf_read(data_off, led_q, num_q, switch, timer_q, cmp_view);

    // Partial confreg writes merge into the register's current contents, which
    // is exactly what the data port would read back at this offset.
    assign conf_new = lane_merge(data_conf, data_sram_wdata, data_sram_wen);

    // A software load of the timer takes priority over the free-running increment.
    assign timer_d = (conf_wr && data_off == OFF_TMR) ? conf_new : timer_q + 32'd1;

    // RAM write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    ram[data_idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef TIMER_IRQ_EN
    logic [31:0] cmp_q;
    logic        irq_q;
    assign cmp_view  = cmp_q;
    assign timer_irq = irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else if (conf_wr && data_off == OFF_CMP) begin
            // Writing compare acknowledges the interrupt, even if it would fire now.
            cmp_q <= conf_new;
            irq_q <= 1'b0;
        end else if (timer_d == cmp_q) begin
            irq_q <= 1'b1;
        end
    end
`else
    assign cmp_view = 32'h0;
`endif

    // Read registers and configuration registers. Reads sample the array before
    // this edge's write lands, so a same-cycle collision returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            led_q        <= 16'hFFFF;
            num_q        <= 32'h0;
            timer_q      <= TIMER_RST;
            bad_q        <= 1'b0;
        end else begin
            if (inst_rd) begin
                inst_rdata_q <= inst_is_conf ? inst_conf : ram[inst_idx];
            end
            if (data_rd) begin
                data_rdata_q <= data_is_conf ? data_conf : ram[data_idx];
            end
            if (inst_bad || data_bad) begin
                bad_q <= 1'b1;
            end
            timer_q <= timer_d;
            if (conf_wr && data_off == OFF_LED) begin
                led_q <= conf_new[15:0];
            end
            if (conf_wr && data_off == OFF_NUM) begin
                num_q <= conf_new;
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign led             = led_q;
    assign num             = num_q;
    assign bad_access      = bad_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder for the core's instruction and data SRAM interfaces: one instruction read port, one data read/write port, one shared word-addressed RAM, plus a small memory-mapped configuration-register window (LEDs, display number, switches, free-running timer).
- Sits outside the core in the SoC top and drives the core's inst_sram_rdata and data_sram_rdata.
- Fixed one-cycle read latency, no wait states, matching the core's pipeline assumption. The IF/ID and EX/MEM stages sample read data the cycle after the request.

Parameters:
- RAM_AW, 12, RAM word-address width; depth = 2^RAM_AW words of 32 bits.
- CONF_HI, 16'hBFAF, value of addr[31:16] that selects the configuration window instead of RAM.
- TIMER_RST, 32'h0, reset value of the timer register.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- inst_sram_en  in  1  instruction request valid
- inst_sram_wen  in  4  byte write enables; must be 0 (port is read-only)
- inst_sram_addr  in  32  byte address
- inst_sram_wdata  in  32  unused
- inst_sram_rdata  out  32  instruction read data, one cycle after request
- data_sram_en  in  1  data request valid
- data_sram_wen  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data, lane-aligned by the requester
- data_sram_rdata  out  32  data read data, one cycle after request
- switch  in  16  board switch inputs
- led  out  16  LED register
- num  out  32  display number register
- bad_access  out  1  sticky error flag

Behaviour:
- Reset:
  - Asynchronous, active-low: rst=0 forces all outputs and registers to reset values immediately, independent of clk.
  - Reset values: inst_sram_rdata=0, data_sram_rdata=0, led=16'hFFFF, num=0, timer=TIMER_RST, bad_access=0.
  - RAM contents are not reset.
  - Reset asserted mid-access: the pending read is discarded and rdata stays 0 on the first cycle after release.
- Decode:
  - Configuration window when addr[31:16]==CONF_HI; RAM otherwise.
  - RAM word index = addr[RAM_AW+1:2]; higher address bits outside the configuration window are ignored (aliasing).
- Reads:
  - Request (en=1, wen=0) at edge N produces rdata valid from edge N+1 until the next edge.
  - With en=0, rdata holds its previous value.
  - addr[1:0] is ignored on reads; the full word is returned.
- Writes (data port only):
  - Applied at the edge where en=1 and wen!=0; byte lane i is written when wen[i]=1.
  - Legal wen patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other nonzero pattern writes nothing and sets bad_access.
  - inst_sram_wen!=0 with inst_sram_en=1 also sets bad_access; no write occurs.
  - A data write returns no read data; data_sram_rdata holds its previous value.
- Same-cycle collision: a data write and an instruction read to the same word use read-before-write, so the instruction port returns the old word. A read on either port in the following cycle returns the new word.
- bad_access is sticky and cleared only by reset.
- Configuration window, offsets by addr[15:0]; unlisted offsets read 0 and ignore writes:
  - 0x0000 led: R/W, low 16 bits.
  - 0x0004 num: R/W.
  - 0x0008 switch: read-only, zero-extended; writes ignored.
  - 0x000C timer:
    - Increments by 1 every cycle and wraps from 32'hFFFFFFFF to 0.
    - A write loads wdata; on that edge the load wins over the increment.
    - A read returns the value before the edge.
  - Byte enables apply to confreg writes the same way as to RAM.
- The instruction port reads the configuration window identically; it never writes it.

Optional Feature:
- Macro TIMER_IRQ_EN.
- When defined:
  - Adds output timer_irq (1 bit, reset 0) and compare register at offset 0x0010 (R/W, reset 32'hFFFFFFFF).
  - timer_irq is set at the edge where the timer's next value equals compare.
  - It stays set until software writes compare; that write clears timer_irq on the same edge.
  - If set and clear occur on the same edge, clear wins.
- When undefined: no timer_irq port, no compare register, and offset 0x0010 reads 0.

Test Plan:
- Reset: hold rst=0, toggle clk 3 cycles -> led=16'hFFFF, num=0, both rdata=0, bad_access=0; deassert -> timer reads 1 after one cycle and 2 after two.
- Write/read: data write addr 0x00000010, wen=1111, wdata 0xDEADBEEF; next cycle data read 0x10 -> data_sram_rdata=0xDEADBEEF one cycle later; inst read 0x10 also returns 0xDEADBEEF.
- Byte lanes: from the word above, write wen=0100 wdata 0x00AA0000 -> read 0xDEAABEEF; then wen=0101 -> bad_access=1, word unchanged.
- Collision: same-cycle data write 0x11111111 and inst read to 0x20 (old 0x0) -> inst rdata=0x0; inst read next cycle -> 0x11111111.
- Confreg: write 0xBFAF0000 with 0x1234 -> led=16'h1234; switch=16'h00F0, read 0xBFAF0008 -> 0x000000F0; write timer 0xFFFFFFFE, read on the next two cycles -> 0xFFFFFFFF, then 0x00000000.
- TIMER_IRQ_EN: compare=5, timer=0 -> timer_irq rises at the edge where timer becomes 5; a compare write on that edge keeps it low; a later compare write clears it.
